// File: rtl/ibex_array_word_serializer.sv
// Serializes a NUM_WORDS-word bundle into one masked word per handshake, in ascending index order.
// Optional per-word parity output and check: define IBEX_ARRAY_SER_PARITY_EN.
module ibex_array_word_serializer #(
  parameter int unsigned WIDTH     = 34,
  parameter int unsigned NUM_WORDS = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [NUM_WORDS-1:0]         in_mask_i,
  input  logic [WIDTH-1:0]             in_data_i [NUM_WORDS],
`ifdef IBEX_ARRAY_SER_PARITY_EN
  input  logic [NUM_WORDS-1:0]         in_parity_chk_i,
  output logic                         out_parity_o,
  output logic                         parity_err_o,
`endif
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [WIDTH-1:0]             out_data_o,
  output logic [$clog2(NUM_WORDS)-1:0] out_idx_o,
  output logic                         out_last_o,
  output logic [CNT_W-1:0]             beat_cnt_o
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS);

  typedef enum logic {IDLE, SEND} state_e;

  state_e               state_q, state_d;
  logic [NUM_WORDS-1:0] mask_q, mask_d;
  logic [WIDTH-1:0]     data_q [NUM_WORDS];
  logic [WIDTH-1:0]     data_d [NUM_WORDS];
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 last_q, last_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                 fire, accept;
`ifdef IBEX_ARRAY_SER_PARITY_EN
  logic [NUM_WORDS-1:0] chk_q, chk_d;
  logic                 parity_q, parity_d;
  logic                 perr_q, perr_d;
`endif

  always_comb begin
    fire       = (state_q == SEND) && out_ready_i;
    // A new bundle may only land in the cycle the final held word leaves.
    in_ready_o = (state_q == IDLE) || (last_q && out_ready_i);
    accept     = in_valid_i && in_ready_o;

    mask_d = mask_q;
    data_d = data_q;
    if (fire) begin
      mask_d[idx_q] = 1'b0;
    end
    if (accept) begin
      mask_d = in_mask_i;
      data_d = in_data_i;
    end

    // Next word is the lowest remaining index; precomputed so outputs come straight from flops.
    idx_d = '0;
    for (int i = NUM_WORDS - 1; i >= 0; i--) begin
      if (mask_d[i]) begin
        idx_d = i[IDX_W-1:0];
      end
    end
    out_data_d = (mask_d != '0) ? data_d[idx_d] : '0;
    last_d     = (mask_d != '0) && ((mask_d & (mask_d - NUM_WORDS'(1))) == '0);
    state_d    = (mask_d != '0) ? SEND : IDLE;
    beat_cnt_d = beat_cnt_q + CNT_W'(fire);

`ifdef IBEX_ARRAY_SER_PARITY_EN
    chk_d    = accept ? in_parity_chk_i : chk_q;
    parity_d = ^out_data_d;
    perr_d   = fire && (parity_q != chk_q[idx_q]);
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        data_q[i] <= '0;
      end
      out_data_q <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      beat_cnt_q <= '0;
`ifdef IBEX_ARRAY_SER_PARITY_EN
      chk_q      <= '0;
      parity_q   <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      data_q     <= data_d;
      out_data_q <= out_data_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef IBEX_ARRAY_SER_PARITY_EN
      chk_q      <= chk_d;
      parity_q   <= parity_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign out_valid_o = (state_q == SEND);
  assign out_data_o  = out_data_q;
  assign out_idx_o   = idx_q;
  assign out_last_o  = last_q;
  assign beat_cnt_o  = beat_cnt_q;
`ifdef IBEX_ARRAY_SER_PARITY_EN
  assign out_parity_o = parity_q;
  assign parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_ibex_array_word_serializer.sv
// Bench for ibex_array_word_serializer: directed scenarios plus random traffic against a word-queue model.
module tb_ibex_array_word_serializer;

  localparam int W = 34;
  localparam int N = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_mask;
  logic [W-1:0]  in_data [N];
  logic [N-1:0]  chk;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [0:0]    out_idx;
  logic          out_last;
  logic [CW-1:0] beat_cnt;
`ifdef IBEX_ARRAY_SER_PARITY_EN
  logic          out_parity;
  logic          parity_err;
`endif

  ibex_array_word_serializer #(.WIDTH(W), .NUM_WORDS(N), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_mask_i(in_mask), .in_data_i(in_data),
`ifdef IBEX_ARRAY_SER_PARITY_EN
    .in_parity_chk_i(chk), .out_parity_o(out_parity), .parity_err_o(parity_err),
`endif
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_idx_o(out_idx), .out_last_o(out_last), .beat_cnt_o(beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [W-1:0] data;
    bit         last;
    bit         chk;
  } word_t;

  word_t q[$];
  int    exp_cnt = 0;
  bit    err_exp = 0;
  bit    last_acc = 0;
  int    n_cmp = 0;
  int    n_fail = 0;

  function automatic bit   e_valid(); return q.size() != 0; endfunction
  function automatic int   e_idx();   return (q.size() != 0) ? q[0].idx : 0; endfunction
  function automatic logic [W-1:0] e_data(); return (q.size() != 0) ? q[0].data : '0; endfunction
  function automatic bit   e_last();  return (q.size() != 0) ? q[0].last : 1'b0; endfunction
  function automatic bit   e_ready(); return (q.size() == 0) || (q.size() == 1 && out_ready); endfunction

  // Each set mask bit becomes one queued word; the highest set index is the last.
  task automatic push_bundle();
    for (int k = 0; k < N; k++) begin
      if (in_mask[k]) begin
        word_t w;
        w.idx = k; w.data = in_data[k]; w.last = 1'b0; w.chk = chk[k];
        q.push_back(w);
      end
    end
    if (q.size() != 0) q[q.size()-1].last = 1'b1;
  endtask

  task automatic tick();
    bit fire, acc, errn;
    fire = e_valid() && out_ready;
    acc  = in_valid && e_ready();
    errn = 1'b0;
    if (fire) begin
      errn = ((^q[0].data) != q[0].chk);
      void'(q.pop_front());
      exp_cnt = (exp_cnt + 1) % (1 << CW);
    end
    if (acc) push_bundle();
    last_acc = acc;
    @(posedge clk);
    err_exp = errn;
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < N; k++) in_data[k] = W'({$urandom(), $urandom()});
    chk = N'($urandom());
  endtask

  task automatic model_reset();
    q.delete();
    exp_cnt = 0;
    err_exp = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_mask = '0; out_ready = 1'b0; chk = '0;
    for (int k = 0; k < N; k++) in_data[k] = '0;
    model_reset();
    @(negedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== 1'b0 || out_last !== 1'b0 ||
        beat_cnt !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b d=%h i=%0d l=%b cnt=%0d rdy=%b, want 0 0 0 0 0 1",
               out_valid, out_data, out_idx, out_last, beat_cnt, in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    // Mid-bundle reset: one word out, then reset while word 1 is pending.
    randomize_inputs(); in_mask = 2'b11; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0; #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 1'b1 || beat_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL pre_reset_word1: got v=%b i=%0d cnt=%0d, want 1 1 1", out_valid, out_idx, beat_cnt);
    end
    #1 rst = 1'b1; #1;
    n_cmp++;
    if (out_valid !== 1'b0 || beat_cnt !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_bundle_reset: got v=%b cnt=%0d rdy=%b, want 0 0 1", out_valid, beat_cnt, in_ready);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_bundle();
    in_data[0] = 34'h0_1234_5678; in_data[1] = 34'h3_FFFF_0000; chk = 2'b00;
    in_mask = 2'b11; in_valid = 1'b1; out_ready = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_idle: got rdy=%b v=%b, want 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0; #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 1'b0 || out_data !== 34'h012345678 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL full_word0: got v=%b i=%0d d=%h l=%b, want 1 0 012345678 0", out_valid, out_idx, out_data, out_last);
    end
    tick(); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 1'b1 || out_data !== 34'h3FFFF0000 || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL full_word1: got v=%b i=%0d d=%h l=%b, want 1 1 3ffff0000 1", out_valid, out_idx, out_data, out_last);
    end
    tick(); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || beat_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL full_done: got v=%b cnt=%0d, want 0 2", out_valid, beat_cnt);
    end
  endtask

  task automatic test_sparse_empty();
    int base;
    base = exp_cnt;
    randomize_inputs(); in_mask = 2'b10; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 1'b1 || out_last !== 1'b1 || out_data !== e_data()) begin
      n_fail++;
      $display("FAIL sparse_word: got v=%b i=%0d l=%b d=%h, want 1 1 1 %h", out_valid, out_idx, out_last, out_data, e_data());
    end
    tick(); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || beat_cnt !== CW'(base + 1)) begin
      n_fail++;
      $display("FAIL sparse_done: got v=%b cnt=%0d, want 0 %0d", out_valid, beat_cnt, base + 1);
    end
    randomize_inputs(); in_mask = 2'b00; in_valid = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_ready: got %b, want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || beat_cnt !== CW'(base + 1)) begin
        n_fail++;
        $display("FAIL empty_mask c=%0d: got v=%b cnt=%0d, want 0 %0d", c, out_valid, beat_cnt, base + 1);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d0, d1;
    randomize_inputs(); d0 = in_data[0]; d1 = in_data[1];
    in_mask = 2'b11; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      randomize_inputs(); in_mask = N'($urandom()); in_valid = 1'b1; #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_idx !== 1'b0 || out_data !== d0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall c=%0d: got v=%b i=%0d d=%h rdy=%b, want 1 0 %h 0", c, out_valid, out_idx, out_data, in_ready, d0);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; #1;
    n_cmp++;
    if (out_idx !== 1'b0 || out_data !== d0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL release_w0: got i=%0d d=%h l=%b, want 0 %h 0", out_idx, out_data, out_last, d0);
    end
    tick(); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 1'b1 || out_data !== d1 || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL release_w1: got v=%b i=%0d d=%h l=%b, want 1 1 %h 1", out_valid, out_idx, out_data, out_last, d1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] b0, b1;
    randomize_inputs(); in_mask = 2'b11; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    randomize_inputs(); b0 = in_data[0]; b1 = in_data[1]; in_mask = 2'b11; in_valid = 1'b1; #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_last !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got rdy=%b l=%b v=%b, want 1 1 1", in_ready, out_last, out_valid);
    end
    tick();
    in_valid = 1'b0; #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 1'b0 || out_data !== b0) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%b i=%0d d=%h, want 1 0 %h", out_valid, out_idx, out_data, b0);
    end
    tick(); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out_idx !== 1'b1 || out_data !== b1) begin
      n_fail++;
      $display("FAIL b2b_second: got v=%b i=%0d d=%h, want 1 1 %h", out_valid, out_idx, out_data, b1);
    end
    // Last word of this bundle meets an empty bundle: must fall back to idle.
    in_mask = 2'b00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || last_acc !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_empty: got v=%b rdy=%b acc=%b, want 0 1 1", out_valid, in_ready, last_acc);
    end
  endtask

  task automatic test_wrap();
    int done;
    rst = 1'b1; model_reset();
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    // 8 full bundles + 1 single-word bundle = 17 beats.
    for (int b = 0; b < 9; b++) begin
      randomize_inputs(); in_mask = (b < 8) ? 2'b11 : 2'b01; in_valid = 1'b1;
      done = 0;
      for (int t = 0; t < 10 && done == 0; t++) begin
        tick();
        if (last_acc) done = 1;
      end
      if (done == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL wrap_accept_timeout: bundle %0d never accepted", b);
      end
    end
    in_valid = 1'b0;
    for (int t = 0; t < 10 && q.size() != 0; t++) tick();
    #1;
    n_cmp++;
    if (beat_cnt !== 4'd1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_count: got cnt=%0d v=%b, want 1 0", beat_cnt, out_valid);
    end
  endtask

`ifdef IBEX_ARRAY_SER_PARITY_EN
  task automatic test_parity();
    int pulses;
    randomize_inputs();
    chk[0] = ^in_data[0];
    chk[1] = ~(^in_data[1]);
    in_mask = 2'b11; in_valid = 1'b1; out_ready = 1'b1;
    pulses = 0;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if (parity_err !== err_exp || (e_valid() && out_parity !== ^e_data())) begin
        n_fail++;
        $display("FAIL parity c=%0d: got err=%b par=%b, want err=%b par=%b", c, parity_err, out_parity, err_exp, ^e_data());
      end
      if (parity_err === 1'b1) pulses++;
      tick();
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL parity_pulses: got %0d, want 1", pulses);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      randomize_inputs();
      in_mask   = N'($urandom());
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      n_cmp++;
      if (out_valid !== e_valid() || in_ready !== e_ready() || beat_cnt !== CW'(exp_cnt) ||
          (e_valid() && (out_idx !== 1'(e_idx()) || out_data !== e_data() || out_last !== e_last()))) begin
        n_fail++;
        $display("FAIL random c=%0d: got v=%b rdy=%b cnt=%0d i=%0d d=%h l=%b, want v=%b rdy=%b cnt=%0d i=%0d d=%h l=%b",
                 c, out_valid, in_ready, beat_cnt, out_idx, out_data, out_last,
                 e_valid(), e_ready(), exp_cnt, e_idx(), e_data(), e_last());
      end
`ifdef IBEX_ARRAY_SER_PARITY_EN
      n_cmp++;
      if (parity_err !== err_exp) begin
        n_fail++;
        $display("FAIL random_parity c=%0d: got %b, want %b", c, parity_err, err_exp);
      end
`endif
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_full_bundle();
    test_sparse_empty();
    test_backpressure();
    test_back_to_back();
    test_wrap();
`ifdef IBEX_ARRAY_SER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
